// File: rtl/if_id_pkg.sv
// Shared constants and state encoding for the fetch-to-decode pipeline register.
package if_id_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // A fetch that raised an address error must not reach decode as a real opcode.
  function automatic logic [31:0] fetch_word(input logic [31:0] inst, input logic adel);
    fetch_word = adel ? NOP_INST : inst;
  endfunction

endpackage

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: main entry feeding decode plus one skid entry that
// absorbs the word already in flight from the one-cycle-latency instruction memory.
module if_id_stage
  import if_id_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        if_adel,
  input  logic        id_stall,
  input  logic        flush,
  input  logic        in_delayslot_in,
  output logic        if_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [5:0]  id_op,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_func,
  output logic [15:0] id_imm16,
  output logic        id_is_delayslot,
  output logic        id_adel
);

  state_t      state;
  state_t      state_nxt;
  logic        pending_ds;

  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic        skid_adel;

  logic        accept;
  logic        advance;
  logic        load_main_in;
  logic        load_main_skid;
  logic        load_skid;
  logic        go_empty;
  logic        ds_new;

  always_comb begin
    accept         = if_valid & if_ready;
    advance        = id_valid & ~id_stall;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    go_empty       = 1'b0;
    state_nxt      = state;
    ds_new         = (advance & in_delayslot_in) | ((state == EMPTY) & pending_ds);

    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (accept && advance) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = TWO;
          end else if (advance) begin
            go_empty  = 1'b1;
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          // if_ready is low here, so no new word competes with the skid.
          if (advance) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Control state and the main entry seen by decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= EMPTY;
      if_ready        <= 1'b1;
      pending_ds      <= 1'b0;
      id_valid        <= 1'b0;
      id_pc           <= PC_RESET;
      id_inst         <= NOP_INST;
      id_adel         <= 1'b0;
      id_is_delayslot <= 1'b0;
    end else begin
      state    <= state_nxt;
      if_ready <= (state_nxt != TWO);
      if (flush) begin
        pending_ds      <= 1'b0;
        id_valid        <= 1'b0;
        id_inst         <= NOP_INST;
        id_adel         <= 1'b0;
        id_is_delayslot <= 1'b0;
      end else if (load_main_in) begin
        pending_ds      <= 1'b0;
        id_valid        <= 1'b1;
        id_pc           <= if_pc;
        id_inst         <= fetch_word(if_inst, if_adel);
        id_adel         <= if_adel;
        id_is_delayslot <= ds_new;
      end else if (load_main_skid) begin
        pending_ds      <= 1'b0;
        id_valid        <= 1'b1;
        id_pc           <= skid_pc;
        id_inst         <= skid_inst;
        id_adel         <= skid_adel;
        id_is_delayslot <= ds_new;
      end else if (go_empty) begin
        // The branch leaves ID with nothing behind it; remember its slot is owed.
        pending_ds      <= in_delayslot_in;
        id_valid        <= 1'b0;
        id_inst         <= NOP_INST;
        id_adel         <= 1'b0;
        id_is_delayslot <= 1'b0;
      end
    end
  end

  // Skid entry: data only, qualified by state
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_pc   <= if_pc;
      skid_inst <= fetch_word(if_inst, if_adel);
      skid_adel <= if_adel;
    end
  end

  assign id_op    = id_inst[31:26];
  assign id_rs    = id_inst[25:21];
  assign id_rt    = id_inst[20:16];
  assign id_rd    = id_inst[15:11];
  assign id_shamt = id_inst[10:6];
  assign id_func  = id_inst[5:0];
  assign id_imm16 = id_inst[15:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios then random traffic, compared
// against a queue-based model of the fetch/decode handoff.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic        id_stall;
  logic        flush;
  logic        in_delayslot_in;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [5:0]  id_op;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_func;
  logic [15:0] id_imm16;
  logic        id_is_delayslot;
  logic        id_adel;

  int checks = 0;
  int errors = 0;

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_adel(if_adel), .id_stall(id_stall), .flush(flush), .in_delayslot_in(in_delayslot_in),
    .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_func(id_func), .id_imm16(id_imm16), .id_is_delayslot(id_is_delayslot), .id_adel(id_adel)
  );

  always #5 clk = ~clk;

  // Model: instructions waiting for decode, oldest at the front (front = main entry).
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ent_t;

  ent_t        q[$];
  logic        m_pend;
  logic        m_head_ds;
  logic [31:0] m_last_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend    = 1'b0;
    m_head_ds = 1'b0;
    m_last_pc = 32'hBFC0_0000;
  endtask

  task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                            input logic adel, input logic stall, input logic fl, input logic ids);
    logic adv, acc, was_empty;
    adv       = (q.size() > 0) && !stall;
    acc       = v && (q.size() < 2);
    was_empty = (q.size() == 0);
    if (fl) begin
      q.delete();
      m_pend    = 1'b0;
      m_head_ds = 1'b0;
    end else begin
      if (adv) void'(q.pop_front());
      if (acc) q.push_back('{pc: pc, inst: (adel ? 32'h0 : inst), adel: adel});
      if (adv) begin
        if (q.size() > 0) begin
          m_head_ds = ids;
          m_pend    = 1'b0;
          m_last_pc = q[0].pc;
        end else begin
          m_pend    = ids;
          m_head_ds = 1'b0;
        end
      end else if (was_empty && acc) begin
        m_head_ds = m_pend;
        m_pend    = 1'b0;
        m_last_pc = q[0].pc;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_inst, e_pc;
    logic        e_adel, e_ds;
    if (q.size() > 0) begin
      e_inst = q[0].inst;
      e_pc   = q[0].pc;
      e_adel = q[0].adel;
      e_ds   = m_head_ds;
    end else begin
      e_inst = 32'h0;
      e_pc   = m_last_pc;
      e_adel = 1'b0;
      e_ds   = 1'b0;
    end
    check({tag, ".if_ready"}, {31'b0, if_ready}, {31'b0, q.size() < 2});
    check({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, q.size() > 0});
    check({tag, ".id_pc"}, id_pc, e_pc);
    check({tag, ".id_inst"}, id_inst, e_inst);
    check({tag, ".fields"}, {id_op, id_rs, id_rt, id_rd, id_shamt, id_func}, e_inst);
    check({tag, ".imm16"}, {16'b0, id_imm16}, {16'b0, e_inst[15:0]});
    check({tag, ".id_adel"}, {31'b0, id_adel}, {31'b0, e_adel});
    check({tag, ".ds"}, {31'b0, id_is_delayslot}, {31'b0, e_ds});
  endtask

  task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic adel, input logic stall,
                       input logic fl, input logic ids);
    if_valid = v; if_pc = pc; if_inst = inst; if_adel = adel;
    id_stall = stall; flush = fl; in_delayslot_in = ids;
    @(posedge clk);
    model_step(v, pc, inst, adel, stall, fl, ids);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    if_valid = 1'b0; if_pc = 32'h0; if_inst = 32'h0; if_adel = 1'b0;
    id_stall = 1'b0; flush = 1'b0; in_delayslot_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst.id_valid", {31'b0, id_valid}, 32'd0);
    check("rst.id_pc", id_pc, 32'hBFC0_0000);
    check("rst.id_inst", id_inst, 32'h0);
    check("rst.if_ready", {31'b0, if_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, no stall
    cycle("s1", 1'b1, 32'hBFC0_0000, 32'h2008_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s1.rt", {27'b0, id_rt}, 32'd8);
    cycle("s2", 1'b1, 32'hBFC0_0004, 32'h2009_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s2.rt", {27'b0, id_rt}, 32'd9);
    cycle("s3", 1'b1, 32'hBFC0_0008, 32'h0109_5020, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s3.inst", id_inst, 32'h0109_5020);
    idle("s4");

    // Skid: stall while two words arrive, a third is refused
    cycle("k1", 1'b1, 32'hBFC0_0010, 32'h2008_0011, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("k2", 1'b1, 32'hBFC0_0014, 32'h2009_0022, 1'b0, 1'b1, 1'b0, 1'b0);
    check("k2.if_ready", {31'b0, if_ready}, 32'd0);
    check("k2.main", id_inst, 32'h2008_0011);
    cycle("k3", 1'b1, 32'hBFC0_0018, 32'h2010_0033, 1'b0, 1'b1, 1'b0, 1'b0);
    check("k3.main", id_inst, 32'h2008_0011);
    cycle("k4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("k4.second", id_inst, 32'h2009_0022);
    idle("k5");
    idle("k6");

    // Delay slot: beq advances while the next word is accepted
    cycle("d1", 1'b1, 32'hBFC0_0020, 32'h1109_0004, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("d2", 1'b1, 32'hBFC0_0024, 32'h2008_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    check("d2.ds", {31'b0, id_is_delayslot}, 32'd1);
    cycle("d3", 1'b1, 32'hBFC0_0028, 32'h1109_0004, 1'b0, 1'b0, 1'b0, 1'b0);
    check("d3.ds", {31'b0, id_is_delayslot}, 32'd0);
    // Same beq, fetch idle: slot owed until the next word arrives
    cycle("d4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("d5");
    cycle("d6", 1'b1, 32'hBFC0_002C, 32'h2009_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    check("d6.ds", {31'b0, id_is_delayslot}, 32'd1);
    idle("d7");

    // Flush while in TWO with a word offered
    cycle("f1", 1'b1, 32'hBFC0_0030, 32'h2008_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("f2", 1'b1, 32'hBFC0_0034, 32'h2009_0002, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("f3", 1'b1, 32'hBFC0_0038, 32'h2010_0003, 1'b0, 1'b1, 1'b1, 1'b1);
    check("f3.id_valid", {31'b0, id_valid}, 32'd0);
    check("f3.if_ready", {31'b0, if_ready}, 32'd1);
    idle("f4");

    // Address error
    cycle("a1", 1'b1, 32'hBFC0_0002, 32'h2008_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    check("a1.inst", id_inst, 32'h0);
    check("a1.adel", {31'b0, id_adel}, 32'd1);
    check("a1.pc", id_pc, 32'hBFC0_0002);
    idle("a2");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", ($urandom_range(0, 3) != 0), {$urandom_range(0, 32'h3FFF), 2'b00} | 32'hBFC0_0000,
            $urandom, ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset mid-operation
    cycle("r1", 1'b1, 32'hBFC0_0040, 32'h2008_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("r2", 1'b1, 32'hBFC0_0044, 32'h2009_0002, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("r3", 1'b1, 32'hBFC0_0048, 32'h2010_0003, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("r4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
